fifo_rd_stream: RTL and testbench

- Read-side drain engine for the team's synchronous pointer FIFO.
- Converts the FIFO read port (rd_en pulse, dout registered one cycle later, empty flag) into a valid/ready stream for downstream consumers.
- Holds a 3-entry skid buffer so full throughput is sustained with no combinational path from m_ready to fifo_rd_en.
- Sits between the FIFO and any stream sink (UART TX, DMA, packer).

---
 rtl/fifo_rd_stream_if.sv | 31 +++
 rtl/fifo_rd_stream.sv | 88 ++++++++
 tb/tb_fifo_rd_stream.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Stream-side bundle for fifo_rd_stream: the FIFO read port plus the
// valid/ready output stream. The master modport is the drain engine; the
// slave modport is the environment (FIFO read side plus stream sink).
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_rd_en;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: turns the registered FIFO read port into a
// valid/ready stream through a 3-entry skid buffer. Read issue uses a credit
// check (occ + inflight < 3) so it never depends on m_ready.
// Optional: define FIFO_RD_STREAM_CNT_EN to add the xfer_cnt and stall outputs.
module fifo_rd_stream #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FIFO_RD_STREAM_CNT_EN
    output logic [15:0] xfer_cnt,
    output logic        stall,
`endif
    fifo_rd_stream_if.master bus
);

    typedef logic [1:0] ptr_t;

    logic [1:0]       occ;
    logic             inflight;
    ptr_t             head;
    ptr_t             tail;
    logic [WIDTH-1:0] mem [3];
    logic [2:0]       credit;
    logic             pop;

    // Circular pointer increment over three slots.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read issue: registered occupancy plus the in-flight word, never m_ready.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        credit         = 3'd0;
        bus.fifo_rd_en = 1'b0;
        credit         = {1'b0, occ} + {2'b00, inflight};
        bus.fifo_rd_en = !rst && !bus.fifo_empty && (credit < 3'd3);
    end

    // Stream side: valid whenever the buffer holds a word; data straight from storage.
    always_comb begin
        bus.m_valid = (occ != 2'd0);
        bus.m_data  = mem[head];
        pop         = bus.m_valid && bus.m_ready;
    end

    // Buffer state: capture the in-flight word, retire accepted words.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            head     <= 2'd0;
            tail     <= 2'd0;
            // NOTE: the three storage slots are cleared so m_data reads zero out of reset.
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            inflight <= bus.fifo_rd_en;
            if (inflight) begin
                mem[tail] <= bus.fifo_dout;
                tail      <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            occ <= occ + {1'b0, inflight} - {1'b0, pop};
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    // Transfer counter (wraps) and one-cycle-late sink stall flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= 16'd0;
            stall    <= 1'b0;
        end else begin
            stall <= bus.m_valid && !bus.m_ready;
            if (pop) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a behavioural FIFO read port feeds the
// DUT, a scoreboard checks stream order, and per-cycle vectors check latency,
// credit limits, overlap of capture and pop, and mid-stream reset.
// Define FIFO_RD_STREAM_CNT_EN to also check xfer_cnt and stall.
module tb_fifo_rd_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    fifo_rd_stream_if #(.WIDTH(8)) bus ();

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] xfer_cnt;
    logic        stall;
`endif

    fifo_rd_stream #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef FIFO_RD_STREAM_CNT_EN
        .xfer_cnt (xfer_cnt),
        .stall    (stall),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: registered read data one cycle after rd_en.
    logic [7:0] fmem [256];
    logic [7:0] rp = 8'd0;
    logic [7:0] wp = 8'd0;
    logic [7:0] dout_q = 8'd0;

    assign bus.fifo_empty = (rp == wp);
    assign bus.fifo_dout  = dout_q;

    always @(posedge clk) begin
        if (flush) begin
            rp <= wp;
        end else if (bus.fifo_rd_en) begin
            dout_q <= fmem[rp];
            rp     <= rp + 8'd1;
        end
    end

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int xfers = 0;
    int stall_seen = 0;
    int total_in = 0;
    bit chk_empty = 1'b0;
    bit hold_pending = 1'b0;
    logic [7:0] held = 8'd0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wp] = d;
        wp = wp + 8'd1;
        exp_q.push_back(d);
        total_in++;
    endtask

    // Sample point of the current cycle: scoreboard, stability, issue rules.
    task automatic settle();
        #1;
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (bus.fifo_rd_en) rd_cnt++;
            if (chk_empty) check("rd_while_empty", 32'(bus.fifo_rd_en && bus.fifo_empty), 0);
            if (hold_pending) begin
                check("hold_valid", 32'(bus.m_valid), 1);
                check("hold_data", 32'(bus.m_data), 32'(held));
            end
            hold_pending = bus.m_valid && !bus.m_ready;
            held         = bus.m_data;
            if (bus.m_valid && bus.m_ready) begin
                xfers++;
                if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 1);
                else check("order", 32'(bus.m_data), 32'(exp_q.pop_front()));
            end
`ifdef FIFO_RD_STREAM_CNT_EN
            if (stall) stall_seen++;
`endif
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cyc();
        check({tag, "_drained"}, 32'(exp_q.size()), 0);
        for (int i = 0; i < 3; i++) cyc();
        settle();
        check({tag, "_idle_valid"}, 32'(bus.m_valid), 0);
        adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Basic vectors: rd_en / m_valid / m_data per cycle after reset release.
    bit         basic_rd    [6] = '{1, 1, 1, 0, 0, 0};
    bit         basic_valid [6] = '{0, 0, 1, 1, 1, 0};
    logic [7:0] basic_data  [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [31:0] ready_pat = 32'hB6D5_A9E3;

    initial begin
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        adv();
        // Reset state, with the FIFO already non-empty.
        push(8'h11); push(8'h22); push(8'h33);
        settle();
        check("rst_valid", 32'(bus.m_valid), 0);
        check("rst_data", 32'(bus.m_data), 0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
        adv();

        // Basic: latency of two cycles, one word per cycle.
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            settle();
            check($sformatf("basic_rd_c%0d", c), 32'(bus.fifo_rd_en), 32'(basic_rd[c]));
            check($sformatf("basic_valid_c%0d", c), 32'(bus.m_valid), 32'(basic_valid[c]));
            if (basic_valid[c]) check($sformatf("basic_data_c%0d", c), 32'(bus.m_data), 32'(basic_data[c]));
            adv();
        end
        check("basic_drained", 32'(exp_q.size()), 0);

        // Backpressure: only three reads issue while the sink stalls.
        bus.m_ready = 1'b0;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) push(8'h40 + 8'(i));
        for (int c = 0; c < 8; c++) cyc();
        settle();
        check("bp_rd_cnt", 32'(rd_cnt), 3);
        check("bp_occ", 32'(dut.occ), 3);
        check("bp_valid", 32'(bus.m_valid), 1);
        check("bp_data", 32'(bus.m_data), 32'h40);
        adv();
        bus.m_ready = 1'b1;
        xfers = 0;
        for (int c = 0; c < 10; c++) cyc();
        check("bp_rate", 32'(xfers), 10);
        drain("bp");

        // Simultaneous capture and pop with occ=2, inflight=1.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        for (int c = 0; c < 3; c++) cyc();
        bus.m_ready = 1'b1;
        settle();
        check("sim_occ_before", 32'(dut.occ), 2);
        check("sim_inflight", 32'(dut.inflight), 1);
        check("sim_rd_blocked", 32'(bus.fifo_rd_en), 0);
        adv();
        settle();
        check("sim_occ_after", 32'(dut.occ), 2);
        check("sim_rd_again", 32'(bus.fifo_rd_en), 1);
        adv();
        drain("sim");

        // Wrap: 20 words in three bursts against a fixed irregular ready pattern.
        chk_empty = 1'b1;
        xfers = 0;
        for (int i = 0; i < 7; i++) push(8'h80 + 8'(i));
        for (int c = 0; c < 150 && xfers < 20; c++) begin
            bus.m_ready = ready_pat[c % 32];
            if (c == 9)  for (int i = 7; i < 14; i++) push(8'h80 + 8'(i));
            if (c == 25) for (int i = 14; i < 20; i++) push(8'h80 + 8'(i));
            cyc();
        end
        check("wrap_count", 32'(xfers), 20);
        bus.m_ready = 1'b1;
        drain("wrap");
        chk_empty = 1'b0;
        settle();
        check("wrap_head", 32'(dut.head), 32'(total_in % 3));
        check("wrap_tail", 32'(dut.tail), 32'(total_in % 3));
        adv();

        // Mid-stream reset with occ=2, inflight=1; FIFO flushed alongside.
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
        for (int c = 0; c < 3; c++) cyc();
        settle();
        check("mr_occ", 32'(dut.occ), 2);
        check("mr_inflight", 32'(dut.inflight), 1);
        adv();
        rst = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        exp_q.delete();
        settle();
        check("mr_valid", 32'(bus.m_valid), 0);
        check("mr_data", 32'(bus.m_data), 0);
        check("mr_rd_en", 32'(bus.fifo_rd_en), 0);
        adv();
        rst = 1'b0;
        bus.m_ready = 1'b1;
        push(8'hA5);
        settle();
        check("mr_rd_c0", 32'(bus.fifo_rd_en), 1);
        adv();
        settle();
        check("mr_valid_c1", 32'(bus.m_valid), 0);
        adv();
        settle();
        check("mr_valid_c2", 32'(bus.m_valid), 1);
        check("mr_data_c2", 32'(bus.m_data), 32'hA5);
        adv();
        drain("mr");

`ifdef FIFO_RD_STREAM_CNT_EN
        // Counter: 5 transfers with exactly two stall cycles, then wrap.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        settle();
        check("cnt_reset", 32'(xfer_cnt), 0);
        check("stall_reset", 32'(stall), 0);
        adv();
        stall_seen = 0;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        for (int c = 0; c < 12; c++) begin
            bus.m_ready = !(c == 3 || c == 4);
            cyc();
        end
        drain("cnt");
        check("cnt_xfers", 32'(xfer_cnt), 5);
        check("cnt_stalls", 32'(stall_seen), 2);
        force dut.xfer_cnt = 16'hFFFF;
        #1;
        release dut.xfer_cnt;
        push(8'hEE);
        drain("cnt_wrap");
        check("cnt_wrap", 32'(xfer_cnt), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
